// File: rtl/bp_update_scheduler.sv
// Write-port scheduler for the branch-prediction tables: FIFOs resolved MEM branches and retires one per free cycle.
// Define BP_INIT_SWEEP_EN to add the INIT/DRAIN init sweep after reset and on reinit.
module bp_update_scheduler #(
   parameter int INDEX_BITS  = 5,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_valid,
   input  logic [INDEX_BITS-1:0] mem_index,
   input  logic                  mem_taken,
   input  logic                  mem_global_pred,
   input  logic                  mem_local_pred,
   input  logic                  reinit,
   input  logic                  tbl_ready,
   output logic                  queue_full,
   output logic                  tbl_we,
   output logic                  tbl_init,
   output logic [INDEX_BITS-1:0] tbl_index,
   output logic                  tbl_taken,
   output logic                  sel_we,
   output logic                  sel_local_correct,
   output logic                  predictor_enable
);
   localparam int PTR_BITS   = $clog2(QUEUE_DEPTH);
   localparam int ENTRY_BITS = INDEX_BITS + 3;
   localparam logic [PTR_BITS:0]     FULL_COUNT = (PTR_BITS+1)'(QUEUE_DEPTH);
   localparam logic [INDEX_BITS-1:0] SWEEP_LAST = '1;

   typedef enum logic [1:0] {ST_INIT = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

`ifdef BP_INIT_SWEEP_EN
   localparam state_t RESET_STATE = ST_INIT;
   localparam logic   SWEEP_EN    = 1'b1;
   logic reinit_req;
   assign reinit_req = reinit;
`else
   // Without the sweep the FSM never leaves RUN; reinit has no effect.
   localparam state_t RESET_STATE = ST_RUN;
   localparam logic   SWEEP_EN    = 1'b0;
   logic reinit_req;
   logic reinit_unused;
   assign reinit_req    = 1'b0;
   assign reinit_unused = reinit;
`endif

   state_t                  state_reg;
   logic [INDEX_BITS-1:0]   sweep_reg;
   logic [PTR_BITS:0]       count_reg;
   logic [PTR_BITS-1:0]     wr_ptr_reg;
   logic [PTR_BITS-1:0]     rd_ptr_reg;
   logic [ENTRY_BITS-1:0]   fifo_reg [QUEUE_DEPTH];

   logic                    push;
   logic                    pop;
   logic [ENTRY_BITS-1:0]   push_entry;
   logic [ENTRY_BITS-1:0]   head;

   assign push_entry = {mem_index, mem_taken,
                        (mem_global_pred == mem_taken), (mem_local_pred == mem_taken)};
   assign head       = fifo_reg[rd_ptr_reg];

   // Only RUN accepts; a full queue is judged on the registered count alone.
   assign push = (state_reg == ST_RUN) && mem_valid && (count_reg != FULL_COUNT);
   assign pop  = ((state_reg == ST_RUN) || (state_reg == ST_DRAIN))
                 && (count_reg != '0) && tbl_ready;

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         fifo_reg[wr_ptr_reg] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= RESET_STATE;
         sweep_reg  <= '0;
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
         end
         case (state_reg)
            ST_RUN: begin
               if (reinit_req) state_reg <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (count_reg == '0) begin
                  sweep_reg <= '0;
                  state_reg <= ST_INIT;
               end
            end
            ST_INIT: begin
               // Counter wraps to 0 on the last write, ready for the next sweep.
               if (tbl_ready) begin
                  sweep_reg <= sweep_reg + 1'b1;
                  if (sweep_reg == SWEEP_LAST) state_reg <= ST_RUN;
               end
            end
            default: state_reg <= RESET_STATE;
         endcase
      end
   end

   always_comb begin
      queue_full        = 1'b1;
      predictor_enable  = 1'b0;
      tbl_we            = 1'b0;
      tbl_init          = 1'b0;
      tbl_index         = '0;
      tbl_taken         = 1'b0;
      sel_we            = 1'b0;
      sel_local_correct = 1'b0;
      if (!rst) begin
         queue_full       = (state_reg != ST_RUN) || (count_reg == FULL_COUNT);
         predictor_enable = SWEEP_EN ? (state_reg == ST_RUN) : 1'b1;
         if (state_reg == ST_INIT) begin
            tbl_we    = tbl_ready;
            sel_we    = tbl_ready;
            tbl_init  = SWEEP_EN;
            tbl_index = sweep_reg;
         end else if (pop) begin
            tbl_we            = 1'b1;
            tbl_index         = head[ENTRY_BITS-1:3];
            tbl_taken         = head[2];
            sel_we            = head[1] ^ head[0];
            sel_local_correct = head[0];
         end
      end
   end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler; the sweep sequences apply when BP_INIT_SWEEP_EN is defined.
module tb_bp_update_scheduler;
   logic       clk = 1'b0;
   logic       rst;
   logic       mem_valid;
   logic [4:0] mem_index;
   logic       mem_taken;
   logic       mem_global_pred;
   logic       mem_local_pred;
   logic       reinit;
   logic       tbl_ready;
   logic       queue_full;
   logic       tbl_we;
   logic       tbl_init;
   logic [4:0] tbl_index;
   logic       tbl_taken;
   logic       sel_we;
   logic       sel_local_correct;
   logic       predictor_enable;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bp_update_scheduler #(.INDEX_BITS(5), .QUEUE_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_index(mem_index), .mem_taken(mem_taken),
      .mem_global_pred(mem_global_pred), .mem_local_pred(mem_local_pred),
      .reinit(reinit), .tbl_ready(tbl_ready), .queue_full(queue_full),
      .tbl_we(tbl_we), .tbl_init(tbl_init), .tbl_index(tbl_index),
      .tbl_taken(tbl_taken), .sel_we(sel_we), .sel_local_correct(sel_local_correct),
      .predictor_enable(predictor_enable)
   );

   // Packed as {we, init, taken, sel_we, sel_local_correct, queue_full, predictor_enable, 4'b0, index}.
   function automatic logic [15:0] pk(input logic we, input logic init, input logic [4:0] idx,
                                      input logic tk, input logic swe, input logic slc,
                                      input logic qf, input logic pe);
      return {we, init, tk, swe, slc, qf, pe, 4'b0000, idx};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic eo(input string tag, input logic we, input logic init, input logic [4:0] idx,
                     input logic tk, input logic swe, input logic slc,
                     input logic qf, input logic pe);
      logic [15:0] obs;
      logic [15:0] exp;
      #1;
      obs = pk(tbl_we, tbl_init, tbl_index, tbl_taken, sel_we, sel_local_correct,
               queue_full, predictor_enable);
      exp = pk(we, init, idx, tk, swe, slc, qf, pe);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b (we,init,tk,swe,slc,qf,pe,0000,idx)", tag, obs, exp);
      end
      $display("check %0d %s observed=%b", checks, tag, obs);
   endtask

   task automatic mv(input logic v, input logic [4:0] i, input logic t, input logic g, input logic l);
      mem_valid       = v;
      mem_index       = i;
      mem_taken       = t;
      mem_global_pred = g;
      mem_local_pred  = l;
   endtask

   initial begin
      rst = 1'b1; tbl_ready = 1'b1; reinit = 1'b0;
      mv(0, 0, 0, 0, 0);
      eo("rst_hold_pre", 0, 0, 0, 0, 0, 0, 1, 0);
      tick(); tick();
      eo("rst_hold", 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      rst = 1'b0;
`ifdef BP_INIT_SWEEP_EN
      for (int i = 0; i < 32; i++) begin
         eo($sformatf("sweep_%0d", i), 1, 1, 5'(i), 0, 1, 0, 1, 0);
         tick();
      end
`endif
      eo("run_idle", 0, 0, 0, 0, 0, 0, 0, 1);

      // Single update: taken, global wrong, local right.
      mv(1, 7, 1, 0, 1);
      eo("no_bypass", 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      mv(0, 0, 0, 0, 0);
      eo("single", 1, 0, 7, 1, 1, 1, 0, 1);
      tick();
      eo("single_done", 0, 0, 0, 0, 0, 0, 0, 1);

      mv(1, 9, 1, 1, 1);
      tick();
      mv(1, 3, 0, 0, 1);
      eo("both_ok", 1, 0, 9, 1, 0, 1, 0, 1);
      tick();
      mv(0, 0, 0, 0, 0);
      eo("global_ok", 1, 0, 3, 0, 1, 0, 0, 1);
      tick();

      // Backpressure: five offers, only four fit.
      tbl_ready = 1'b0;
      mv(1, 10, 1, 1, 0); eo("bp_fill0", 0, 0, 0, 0, 0, 0, 0, 1); tick();
      mv(1, 11, 0, 0, 0); eo("bp_fill1", 0, 0, 0, 0, 0, 0, 0, 1); tick();
      mv(1, 12, 1, 0, 1); eo("bp_fill2", 0, 0, 0, 0, 0, 0, 0, 1); tick();
      mv(1, 13, 0, 1, 1); eo("bp_fill3", 0, 0, 0, 0, 0, 0, 0, 1); tick();
      mv(1, 14, 1, 0, 0); eo("bp_full", 0, 0, 0, 0, 0, 0, 1, 1); tick();
      mv(0, 0, 0, 0, 0);
      tbl_ready = 1'b1;
      eo("retire_10", 1, 0, 10, 1, 1, 0, 1, 1);
      tick();
      mv(1, 20, 1, 1, 1);
      eo("retire_11_push", 1, 0, 11, 0, 0, 1, 0, 1);
      tick();
      tbl_ready = 1'b0;
      mv(1, 21, 0, 0, 1);
      eo("hold_push", 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      mv(0, 0, 0, 0, 0);
      eo("full_again", 0, 0, 0, 0, 0, 0, 1, 1);
      tick();
      tbl_ready = 1'b1;
      eo("retire_12", 1, 0, 12, 1, 1, 1, 1, 1); tick();
      eo("retire_13", 1, 0, 13, 0, 0, 0, 0, 1); tick();
      eo("retire_20", 1, 0, 20, 1, 0, 1, 0, 1); tick();
      eo("retire_21", 1, 0, 21, 0, 1, 0, 0, 1); tick();
      eo("retire_empty", 0, 0, 0, 0, 0, 0, 0, 1);

`ifdef BP_INIT_SWEEP_EN
      // reinit with three queued entries: drain, then sweep; a second reinit is ignored.
      tbl_ready = 1'b0;
      mv(1, 4, 1, 1, 0); tick();
      mv(1, 6, 0, 1, 1); tick();
      mv(1, 8, 1, 0, 1); tick();
      mv(0, 0, 0, 0, 0);
      reinit = 1'b1;
      tbl_ready = 1'b1;
      eo("reinit_w4", 1, 0, 4, 1, 1, 0, 0, 1);
      tick();
      reinit = 1'b0;
      eo("drain_w6", 1, 0, 6, 0, 0, 0, 1, 0); tick();
      eo("drain_w8", 1, 0, 8, 1, 1, 1, 1, 0); tick();
      eo("drain_empty", 0, 0, 0, 0, 0, 0, 1, 0); tick();
      for (int i = 0; i < 32; i++) begin
         reinit = (i == 5);
         eo($sformatf("resweep_%0d", i), 1, 1, 5'(i), 0, 1, 0, 1, 0);
         tick();
      end
      reinit = 1'b0;
      eo("resweep_done", 0, 0, 0, 0, 0, 0, 0, 1);

      // Reset with a populated queue, then again at sweep index 12.
      tbl_ready = 1'b0;
      mv(1, 2, 1, 1, 1); tick();
      mv(1, 3, 0, 0, 0); tick();
      mv(0, 0, 0, 0, 0);
      rst = 1'b1;
      tbl_ready = 1'b1;
      eo("rst_queued", 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         eo($sformatf("sweep_a_%0d", i), 1, 1, 5'(i), 0, 1, 0, 1, 0);
         tick();
      end
      eo("sweep_a_12", 1, 1, 12, 0, 1, 0, 1, 0);
      rst = 1'b1;
      eo("rst_mid_sweep", 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         eo($sformatf("sweep_b_%0d", i), 1, 1, 5'(i), 0, 1, 0, 1, 0);
         tick();
      end
      eo("rst_discard", 0, 0, 0, 0, 0, 0, 0, 1);
`else
      // Without the sweep, reinit does nothing.
      tbl_ready = 1'b0;
      mv(1, 5, 1, 1, 1); tick();
      mv(0, 0, 0, 0, 0);
      reinit = 1'b1;
      eo("reinit_ign", 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      reinit = 1'b0;
      eo("reinit_ign2", 0, 0, 0, 0, 0, 0, 0, 1);
      tbl_ready = 1'b1;
      eo("after_reinit", 1, 0, 5, 1, 0, 1, 0, 1);
      tick();
      eo("after_reinit_empty", 0, 0, 0, 0, 0, 0, 0, 1);

      // Reset with a populated queue discards it.
      tbl_ready = 1'b0;
      mv(1, 2, 1, 1, 1); tick();
      mv(1, 3, 0, 0, 0); tick();
      mv(0, 0, 0, 0, 0);
      rst = 1'b1;
      tbl_ready = 1'b1;
      eo("rst_queued", 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      eo("rst_queued2", 0, 0, 0, 0, 0, 0, 1, 0);
      rst = 1'b0;
      eo("rst_discard", 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      eo("rst_discard2", 0, 0, 0, 0, 0, 0, 0, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
